// File: rtl/serial_frame_pkg.sv
// Shared frame constants, header patterns and state encodings for the serial deframer.
// Pure definitions; no timing of its own.
package serial_frame_pkg;

    localparam int BYTES_PER_FRAME     = 10;
    localparam int DATA_BYTES_PER_CHAN = 4;

    localparam logic [7:0] HDR0_MASK = 8'h80;
    localparam logic [7:0] HDR0_VAL  = 8'h80;
    localparam logic [7:0] HDR1_MASK = 8'hF0;
    localparam logic [7:0] HDR1_VAL  = 8'h40;

    typedef enum logic [1:0] {
        DF_HUNT,
        DF_C0,
        DF_H1,
        DF_C1
    } deframe_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    function automatic logic hdr_match(input logic [7:0] b,
                                       input logic [7:0] mask,
                                       input logic [7:0] val);
        return (b & mask) == val;
    endfunction

endpackage

// File: rtl/serial_rx_byte.sv
// Oversampling UART byte receiver: 2-flop sync, start validation at half bit, 8 data + 1 stop sample.
// Strobes land 1 cycle after the stop-bit sample; no backpressure, bytes must be consumed on the strobe.
module serial_rx_byte
    import serial_frame_pkg::*;
#(
    parameter int OVS = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_vld_o,
    output logic       byte_err_o,
    output logic       start_o
);

    localparam int CW = (OVS > 2) ? $clog2(OVS) : 1;

    logic            sync1_q, sync2_q, prev_q;
    logic            fall;
    rx_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            byte_vld_q, byte_vld_d;
    logic            byte_err_q, byte_err_d;
    logic            start_q, start_d;

    assign fall = prev_q & ~sync2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            state_q    <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            byte_vld_q <= 1'b0;
            byte_err_q <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            sync1_q    <= rx_i;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            byte_vld_q <= byte_vld_d;
            byte_err_q <= byte_err_d;
            start_q    <= start_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_vld_d = 1'b0;
        byte_err_d = 1'b0;
        start_d    = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (fall) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                // Half-bit check rejects short glitches on the idle line.
                if (cnt_q == CW'(OVS / 2 - 1)) begin
                    cnt_d = '0;
                    if (!sync2_q) begin
                        state_d = RX_DATA;
                        bit_d   = '0;
                        start_d = 1'b1;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == CW'(OVS - 1)) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = RX_STOP;
                    else               bit_d   = bit_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == CW'(OVS - 1)) begin
                    cnt_d      = '0;
                    state_d    = RX_IDLE;
                    byte_vld_d = sync2_q;
                    byte_err_d = ~sync2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_o     = shift_q;
    assign byte_vld_o = byte_vld_q;
    assign byte_err_o = byte_err_q;
    assign start_o    = start_q;

endmodule

// File: rtl/serial_recv.sv
// Deframes 10-byte serial frames into chan0/chan1; valid 1 cycle after the 10th byte strobe.
// No backpressure; SERIAL_RECV_STATS_EN adds saturating good/error frame counters.
module serial_recv
    import serial_frame_pkg::*;
#(
    parameter int OVS          = 8,
    parameter int TIMEOUT_BITS = 24
) (
    input  logic        sclk,
    input  logic        rst,
    input  logic        idata,
    output logic [31:0] chan0,
    output logic [31:0] chan1,
    output logic        valid,
    output logic        frame_err
`ifdef SERIAL_RECV_STATS_EN
    ,
    output logic [15:0] good_cnt,
    output logic [15:0] err_cnt
`endif
);

    localparam int CW = (OVS > 2) ? $clog2(OVS) : 1;
    localparam int TW = $clog2(TIMEOUT_BITS + 1);

    logic [7:0]     rx_byte;
    logic           rx_vld, rx_err, rx_start;

    serial_rx_byte #(.OVS(OVS)) u_rx (
        .clk_i      (sclk),
        .rst_i      (rst),
        .rx_i       (idata),
        .byte_o     (rx_byte),
        .byte_vld_o (rx_vld),
        .byte_err_o (rx_err),
        .start_o    (rx_start)
    );

    deframe_state_t st_q, st_d;
    logic [1:0]     idx_q, idx_d;
    logic [3:0]     nib0_q, nib0_d, nib1_q, nib1_d;
    logic [31:0]    c0_q, c0_d, c1_q, c1_d;
    logic [31:0]    chan0_q, chan0_d, chan1_q, chan1_d;
    logic           valid_q, valid_d, ferr_q, ferr_d;
    logic [CW-1:0]  tick_q, tick_d;
    logic [TW-1:0]  bits_q, bits_d;
    logic           timeout, abort;

    always_ff @(posedge sclk) begin
        if (rst) begin
            st_q    <= DF_HUNT;
            idx_q   <= '0;
            nib0_q  <= '0;
            nib1_q  <= '0;
            c0_q    <= '0;
            c1_q    <= '0;
            chan0_q <= '0;
            chan1_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            tick_q  <= '0;
            bits_q  <= '0;
        end else begin
            st_q    <= st_d;
            idx_q   <= idx_d;
            nib0_q  <= nib0_d;
            nib1_q  <= nib1_d;
            c0_q    <= c0_d;
            c1_q    <= c1_d;
            chan0_q <= chan0_d;
            chan1_q <= chan1_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            tick_q  <= tick_d;
            bits_q  <= bits_d;
        end
    end

    // Idle bit-time counter, restarted by every start or byte, held clear while hunting.
    always_comb begin
        tick_d = tick_q;
        bits_d = bits_q;
        if (st_q == DF_HUNT || rx_vld || rx_start) begin
            tick_d = '0;
            bits_d = '0;
        end else if (tick_q == CW'(OVS - 1)) begin
            tick_d = '0;
            if (bits_q < TW'(TIMEOUT_BITS)) bits_d = bits_q + 1'b1;
        end else begin
            tick_d = tick_q + 1'b1;
        end
    end

    assign timeout = (st_q != DF_HUNT) && (bits_q >= TW'(TIMEOUT_BITS));

    always_comb begin
        st_d    = st_q;
        idx_d   = idx_q;
        nib0_d  = nib0_q;
        nib1_d  = nib1_q;
        c0_d    = c0_q;
        c1_d    = c1_q;
        chan0_d = chan0_q;
        chan1_d = chan1_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        abort   = 1'b0;
        if (st_q != DF_HUNT && (rx_err || timeout)) begin
            abort = 1'b1;
        end else if (rx_vld) begin
            case (st_q)
                DF_HUNT: begin
                    if (hdr_match(rx_byte, HDR0_MASK, HDR0_VAL)) begin
                        nib0_d = rx_byte[3:0];
                        idx_d  = '0;
                        st_d   = DF_C0;
                    end
                end
                DF_C0: begin
                    if (rx_byte[7]) begin
                        abort = 1'b1;
                    end else begin
                        c0_d[{idx_q, 3'b000} +: 8] = {nib0_q[idx_q], rx_byte[6:0]};
                        if (idx_q == 2'(DATA_BYTES_PER_CHAN - 1)) st_d = DF_H1;
                        else                                      idx_d = idx_q + 1'b1;
                    end
                end
                DF_H1: begin
                    if (!hdr_match(rx_byte, HDR1_MASK, HDR1_VAL)) begin
                        abort = 1'b1;
                    end else begin
                        nib1_d = rx_byte[3:0];
                        idx_d  = '0;
                        st_d   = DF_C1;
                    end
                end
                DF_C1: begin
                    if (rx_byte[7]) begin
                        abort = 1'b1;
                    end else begin
                        c1_d[{idx_q, 3'b000} +: 8] = {nib1_q[idx_q], rx_byte[6:0]};
                        if (idx_q == 2'(DATA_BYTES_PER_CHAN - 1)) begin
                            chan0_d = c0_q;
                            chan1_d = c1_d;
                            valid_d = 1'b1;
                            st_d    = DF_HUNT;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                default: st_d = DF_HUNT;
            endcase
        end
        if (abort) begin
            st_d   = DF_HUNT;
            idx_d  = '0;
            ferr_d = 1'b1;
        end
    end

    assign chan0     = chan0_q;
    assign chan1     = chan1_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;

`ifdef SERIAL_RECV_STATS_EN
    logic [15:0] good_cnt_q, err_cnt_q;

    always_ff @(posedge sclk) begin
        if (rst) begin
            good_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (valid_q && good_cnt_q != 16'hFFFF) good_cnt_q <= good_cnt_q + 1'b1;
            if (ferr_q && err_cnt_q != 16'hFFFF)   err_cnt_q  <= err_cnt_q + 1'b1;
        end
    end

    assign good_cnt = good_cnt_q;
    assign err_cnt  = err_cnt_q;
`endif

endmodule
